// File: rtl/bin_to_gray_4bit_if.sv
// Bus bundle for the registered binary-to-Gray converter.
// Ports carried: bin/in_valid (towards the converter), gray/bin_q/out_valid
// (from the converter), plus step_err when BTOG_STEP_CHECK_EN is defined.
interface bin_to_gray_4bit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] bin;
  logic             in_valid;
  logic [WIDTH-1:0] gray;
  logic             out_valid;
  logic [WIDTH-1:0] bin_q;
`ifdef BTOG_STEP_CHECK_EN
  logic             step_err;
`endif

  // Converter side: samples bin/in_valid, drives the registered results.
  modport slave (
    input  bin,
    input  in_valid,
    output gray,
    output out_valid,
`ifdef BTOG_STEP_CHECK_EN
    output step_err,
`endif
    output bin_q
  );

  // Producer/consumer side: drives bin/in_valid, observes the results.
  modport master (
    output bin,
    output in_valid,
    input  gray,
    input  out_valid,
`ifdef BTOG_STEP_CHECK_EN
    input  step_err,
`endif
    input  bin_q
  );
endinterface

// File: rtl/bin_to_gray_4bit.sv
// Registered binary-to-Gray converter: gray = bin ^ (bin >> 1).
// Latency 1 cycle: input accepted at edge N appears on gray/bin_q after edge N.
// No backpressure: one result per accepted input, in_valid may stay high.
//
// Ports: clk (rising edge), rst_n (async active-low), bus (slave modport):
//   bin/in_valid in; gray, bin_q, out_valid out; step_err out when the
//   optional macro BTOG_STEP_CHECK_EN is defined (flags a Gray step on an
//   incrementing input whose Hamming distance is not exactly 1).
module bin_to_gray_4bit #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bin_to_gray_4bit_if.slave      bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_hold_q, bin_hold_d;
  logic             vld_q, vld_d;

`ifdef BTOG_STEP_CHECK_EN
  logic             have_prev_q, have_prev_d;
  logic             step_err_q, step_err_d;
  logic [WIDTH-1:0] diff;
`endif

  always_comb begin
    vld_d      = bus.in_valid;
    gray_d     = gray_q;
    bin_hold_d = bin_hold_q;
    if (bus.in_valid) begin
      bin_hold_d = bus.bin;
      gray_d     = bus.bin ^ (bus.bin >> 1);
    end
  end

`ifdef BTOG_STEP_CHECK_EN
  // Only an increment of the previous accepted word is judged; the first word
  // after reset has no predecessor. A single-bit change is a non-zero power of
  // two, i.e. diff != 0 and diff & (diff - 1) == 0.
  always_comb begin
    have_prev_d = have_prev_q | bus.in_valid;
    step_err_d  = 1'b0;
    diff        = gray_d ^ gray_q;
    if (bus.in_valid && have_prev_q && (bus.bin == bin_hold_q + ONE)) begin
      step_err_d = !((diff != '0) && ((diff & (diff - ONE)) == '0));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q     <= '0;
      bin_hold_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      gray_q     <= gray_d;
      bin_hold_q <= bin_hold_d;
      vld_q      <= vld_d;
    end
  end

`ifdef BTOG_STEP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      have_prev_q <= have_prev_d;
      step_err_q  <= step_err_d;
    end
  end

  assign bus.step_err = step_err_q;
`endif

  assign bus.gray      = gray_q;
  assign bus.bin_q     = bin_hold_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_bin_to_gray_4bit.sv
// Directed bench for bin_to_gray_4bit (WIDTH=4 and WIDTH=8 instances).
// Expected results are queued when a word is driven and popped one cycle later.
module tb_bin_to_gray_4bit;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
  } exp_t;

  logic clk;
  logic rst_n;

  bin_to_gray_4bit_if #(.WIDTH(4)) bus4 ();
  bin_to_gray_4bit_if #(.WIDTH(8)) bus8 ();

  bin_to_gray_4bit #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  bin_to_gray_4bit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Gray table for WIDTH=4, indexed by the binary value.
  logic [3:0] ref_gray [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] last_g   = 4'b0000;
  logic [3:0] last_b   = 4'b0000;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_gray"},  {4'b0, bus4.gray},  8'h00);
    check({tag, "_binq"},  {4'b0, bus4.bin_q}, 8'h00);
    check({tag, "_vld"},   {7'b0, bus4.out_valid}, 8'h00);
`ifdef BTOG_STEP_CHECK_EN
    check({tag, "_serr"},  {7'b0, bus4.step_err}, 8'h00);
`endif
  endtask

  // Drive one word at the falling edge, then check the result after the next rising edge.
  task automatic step(input logic [3:0] b, input logic v);
    exp_t e;
    @(negedge clk);
    bus4.bin      = b;
    bus4.in_valid = v;
    if (v) sb.push_back('{b: b, g: ref_gray[b]});
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        check("sb_empty", 8'h01, 8'h00);
      end else begin
        e = sb.pop_front();
        check("gray",  {4'b0, bus4.gray},  {4'b0, e.g});
        check("bin_q", {4'b0, bus4.bin_q}, {4'b0, e.b});
        last_g = e.g;
        last_b = e.b;
      end
      check("out_valid", {7'b0, bus4.out_valid}, 8'h01);
    end else begin
      check("idle_vld",   {7'b0, bus4.out_valid}, 8'h00);
      check("idle_gray",  {4'b0, bus4.gray},  {4'b0, last_g});
      check("idle_bin_q", {4'b0, bus4.bin_q}, {4'b0, last_b});
    end
`ifdef BTOG_STEP_CHECK_EN
    check("step_err", {7'b0, bus4.step_err}, 8'h00);
`endif
  endtask

  initial begin
    // Reset held with active-looking stimulus on the bus.
    rst_n         = 1'b0;
    bus4.bin      = 4'b1010;
    bus4.in_valid = 1'b1;
    bus8.bin      = 8'h00;
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero4("rst");
    end
    check("rst_gray8", bus8.gray, 8'h00);

    @(negedge clk);
    bus4.in_valid = 1'b0;
    rst_n = 1'b1;

    // Exhaustive sweep, back to back, then wrap to 0000.
    for (int i = 0; i < 16; i++) step(4'(i), 1'b1);
    step(4'b0000, 1'b1);

    // Non-incrementing pair.
    step(4'b0010, 1'b1);
    step(4'b0111, 1'b1);

    // Idle hold.
    step(4'b0110, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1001, 1'b0);

    // Async reset mid-stream: the second sweep stops at 1011.
    for (int i = 0; i < 12; i++) step(4'(i), 1'b1);
    #2;
    rst_n         = 1'b0;
    bus4.in_valid = 1'b0;
    #1;
    check_zero4("async_rst");
    sb.delete();
    last_g = 4'b0000;
    last_b = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0011, 1'b1);
    step(4'b0100, 1'b1);

    // Wide instance.
    @(negedge clk);
    bus8.bin      = 8'hFF;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("w8_gray_ff", bus8.gray, 8'h80);
    check("w8_vld",     {7'b0, bus8.out_valid}, 8'h01);
    @(negedge clk);
    bus8.bin = 8'hA5;
    @(posedge clk);
    #1;
    check("w8_gray_a5", bus8.gray,  8'hF7);
    check("w8_bin_q",   bus8.bin_q, 8'hA5);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w8_idle_vld",  {7'b0, bus8.out_valid}, 8'h00);
    check("w8_idle_gray", bus8.gray, 8'hF7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_4bit.md
Name:
bin_to_gray_4bit

Overview:
- Registered binary-to-Gray-code converter. Default width is 4 bits.
- Takes a binary word with a valid strobe and produces the reflected-binary Gray code one clock later, with a matching valid strobe.
- Used as a pipeline stage ahead of counters, encoders or clock-domain-crossing pointers that need single-bit-change codes.

Parameters:
- WIDTH, 4, bit width of the binary input and the Gray output (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bin  input  WIDTH  binary word to convert.
- in_valid  input  1  bin is sampled on a clk rising edge only when this is high.
- gray  output  WIDTH  registered Gray code of the last accepted bin.
- out_valid  output  1  high for exactly one cycle after each accepted input.
- bin_q  output  WIDTH  registered copy of the last accepted bin, aligned with gray.

Behaviour:
- Reset: while rst_n is low, gray=0, bin_q=0 and out_valid=0, regardless of clk.
  - Assertion takes effect immediately.
  - Release is synchronised by the design to the next clk edge: the first capture happens no earlier than the first rising edge after rst_n goes high.
- Conversion rule:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] XOR bin[i] for i = WIDTH-2 down to 0.
  - Equivalently, gray = bin XOR (bin >> 1) using a logical shift.
- Latency: 1 cycle. A value presented with in_valid=1 at edge N appears on gray/bin_q after edge N, with out_valid=1 during that following cycle.
- Rising edge with in_valid=0: out_valid goes to 0; gray and bin_q hold their previous values.
- Back-to-back: in_valid may stay high every cycle. One result per cycle, no stalls, no backpressure.
- Input X/Z: there is no special handling. Only the behaviour for 0/1 inputs is specified.
- Reset mid-stream: any in-flight result is discarded; all outputs return to 0 immediately.
- Full-range wrap: gray for 4'b1111 is 4'b1000, and the next code (0000→0000) differs from it in one bit.
- Reference values for WIDTH=4, listed bin→gray:
  - 0000→0000, 0001→0001, 0010→0011, 0011→0010
  - 0100→0110, 0101→0111, 0110→0101, 0111→0100
  - 1000→1100, 1001→1101, 1010→1111, 1011→1110
  - 1100→1010, 1101→1011, 1110→1001, 1111→1000

Optional Feature:
- Macro BTOG_STEP_CHECK_EN.
- When defined, the block adds an output step_err (1 bit, registered, reset 0).
  - On each accepted input that equals the previous accepted bin plus 1, modulo 2^WIDTH, the block computes the Hamming distance between the new gray and the previous gray.
  - step_err=1 for one cycle, aligned with out_valid, if that distance is not exactly 1. Otherwise step_err=0.
  - The first accepted input after reset never flags.
  - Non-incrementing inputs never flag.
- When undefined, the step_err port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with bin=1010, in_valid=1, clk running → gray=0000, bin_q=0000, out_valid=0 throughout.
- Exhaustive sweep: after reset, drive bin 0000..1111 with in_valid=1, one per cycle → each gray matches the reference list one cycle later (e.g. 0101→0111, 1111→1000); out_valid stays high for the sweep.
- Idle hold: accept bin=0110 (→gray 0101), then drop in_valid for 3 cycles → out_valid=0 on those cycles, gray stays 0101, bin_q stays 0110.
- Async reset mid-stream: during the sweep at bin=1011, pull rst_n low between clk edges → gray, bin_q and out_valid go to 0 immediately, without waiting for a clk edge; after release, bin=0011 → gray=0010.
- Step check (BTOG_STEP_CHECK_EN): sweep 0000..1111 then 0000 → step_err stays 0 throughout; feed 0010 then 0111 (non-increment) → step_err stays 0.
- Parameter: WIDTH=8, bin=8'hFF → gray=8'h80; bin=8'hA5 → gray=8'hF7.
